// File: rtl/mdu_div_unit_pkg.sv
// Shared types and constants for the E-stage iterative divider.
package mdu_div_unit_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_t;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_CNT_W = 6;

  // Divide-by-zero result: quotient is all ones, remainder is the raw dividend.
  localparam logic DIV_ZERO_LO_FILL = 1'b1;
  localparam logic [DIV_WIDTH-1:0] DIV_ZERO_LO = {DIV_WIDTH{DIV_ZERO_LO_FILL}};

endpackage

// File: rtl/mdu_div_unit_restoring_step.sv
// One restoring-division step: shift {rem,quo} left by one and subtract the
// divisor when it fits. Purely combinational, so it can be chained for a
// multi-bit-per-cycle variant.
module div_restoring_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic [WIDTH-1:0] quo_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic [WIDTH-1:0] quo_out
);

  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] diff;
  logic             fits;

  // rem < divisor on entry, so the shifted value is < 2*divisor and the
  // difference (when it fits) always lands back inside WIDTH bits.
  always_comb begin
    rem_sh  = {rem_in, quo_in[WIDTH-1]};
    fits    = (rem_sh >= {1'b0, divisor});
    diff    = rem_sh[WIDTH-1:0] - divisor;
    rem_out = fits ? diff : rem_sh[WIDTH-1:0];
    quo_out = {quo_in[WIDTH-2:0], fits};
  end

endmodule

// File: rtl/mdu_div_unit.sv
// E-stage multi-cycle DIV/DIVU unit. Stalls the pipeline while a divide is in
// flight, holds a registered HI/LO result in DONE until the instruction leaves
// E, and drops everything on an M-stage exception.
module mdu_div_unit
  import mdu_div_unit_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CNT_W = DIV_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             E_div_start,
  input  logic             E_div_signed,
  input  logic [WIDTH-1:0] E_src_a,
  input  logic [WIDTH-1:0] E_src_b,
  input  logic             longest_stall,
  input  logic             M_except,
  output logic             E_alu_stall,
  output logic [WIDTH-1:0] E_div_hi,
  output logic [WIDTH-1:0] E_div_lo,
  output logic             E_div_valid
);

  div_state_t       state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] rem, quo, dvs;
  logic [WIDTH-1:0] rem_nxt, quo_nxt;
  logic             neg_quo, neg_rem;
  logic             accept, last_step;
  logic             a_neg, b_neg, b_zero;
  logic [WIDTH-1:0] a_mag, b_mag;

  // Operand magnitudes; the most negative value wraps to itself, which is
  // still the correct unsigned magnitude.
  always_comb begin
    a_neg  = E_div_signed & E_src_a[WIDTH-1];
    b_neg  = E_div_signed & E_src_b[WIDTH-1];
    a_mag  = a_neg ? -E_src_a : E_src_a;
    b_mag  = b_neg ? -E_src_b : E_src_b;
    b_zero = (E_src_b == '0);
  end

  div_restoring_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (rem),
    .quo_in  (quo),
    .divisor (dvs),
    .rem_out (rem_nxt),
    .quo_out (quo_nxt)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state and stall request; the stall never looks at longest_stall.
  always_comb begin
    state_nxt   = state;
    E_alu_stall = 1'b0;
    accept      = 1'b0;
    last_step   = 1'b0;
    case (state)
      IDLE: begin
        if (E_div_start && !M_except) begin
          accept      = 1'b1;
          E_alu_stall = 1'b1;
          state_nxt   = b_zero ? DONE : BUSY;
        end
      end
      BUSY: begin
        E_alu_stall = 1'b1;
        if (M_except) begin
          state_nxt = IDLE;
        end else if (cnt == CNT_W'(WIDTH-1)) begin
          last_step = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (M_except || !longest_stall) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: operand latch, iteration, sign fix-up and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      rem         <= '0;
      quo         <= '0;
      dvs         <= '0;
      neg_quo     <= 1'b0;
      neg_rem     <= 1'b0;
      E_div_hi    <= '0;
      E_div_lo    <= '0;
      E_div_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            cnt     <= '0;
            rem     <= '0;
            quo     <= a_mag;
            dvs     <= b_mag;
            neg_quo <= a_neg ^ b_neg;
            neg_rem <= a_neg;
            if (b_zero) begin
              E_div_hi    <= E_src_a;
              E_div_lo    <= {WIDTH{DIV_ZERO_LO_FILL}};
              E_div_valid <= 1'b1;
            end
          end
        end
        BUSY: begin
          if (!M_except) begin
            rem <= rem_nxt;
            quo <= quo_nxt;
            cnt <= cnt + CNT_W'(1);
            if (last_step) begin
              E_div_lo    <= neg_quo ? -quo_nxt : quo_nxt;
              E_div_hi    <= neg_rem ? -rem_nxt : rem_nxt;
              E_div_valid <= 1'b1;
            end
          end
        end
        DONE: begin
          if (M_except || !longest_stall) E_div_valid <= 1'b0;
        end
        default: E_div_valid <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_div_unit.sv
// Scoreboard bench for mdu_div_unit: stimulus pushes reference results, a
// negedge monitor pops and compares whenever a new result appears.
module tb_mdu_div_unit;

  typedef struct {
    logic [31:0] lo;
    logic [31:0] hi;
  } exp_t;

  logic        clk, rst;
  logic        start, sgn, mexc, hold;
  logic [31:0] a, b;
  logic        longest_stall;
  logic        stall, valid;
  logic [31:0] hi, lo;

  int   n_cmp = 0;
  int   n_err = 0;
  exp_t exp_q[$];
  logic prev_v;

  mdu_div_unit dut (
    .clk           (clk),
    .rst           (rst),
    .E_div_start   (start),
    .E_div_signed  (sgn),
    .E_src_a       (a),
    .E_src_b       (b),
    .longest_stall (longest_stall),
    .M_except      (mexc),
    .E_alu_stall   (stall),
    .E_div_hi      (hi),
    .E_div_lo      (lo),
    .E_div_valid   (valid)
  );

  // Hazard unit stand-in: our own stall plus an optional external hold.
  assign longest_stall = stall | hold;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [31:0] x, input logic [31:0] y, input logic s);
    exp_t   e;
    longint sx, sy, qq, rr;
    if (y == 32'd0) begin
      e.lo = 32'hFFFF_FFFF;
      e.hi = x;
    end else if (s) begin
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      qq = sx / sy;
      rr = sx % sy;
      e.lo = qq[31:0];
      e.hi = rr[31:0];
    end else begin
      e.lo = x / y;
      e.hi = x % y;
    end
    return e;
  endfunction

  // Monitor: compare on each fresh result (rising edge of valid).
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_v = 1'b0;
    end else begin
      if (valid && !prev_v) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_result: got lo=%0h hi=%0h with no expected entry", lo, hi);
        end else begin
          e = exp_q.pop_front();
          chk("result_lo", lo, e.lo);
          chk("result_hi", hi, e.hi);
        end
      end
      prev_v = valid;
    end
  end

  // Issue one divide from an IDLE negedge; returns at the IDLE negedge after.
  task automatic do_div(input logic [31:0] x, input logic [31:0] y, input logic s, input int hold_n);
    exp_t e;
    int   st;
    bit   got;
    e = model(x, y, s);
    exp_q.push_back(e);
    start = 1'b1; sgn = s; a = x; b = y;
    #1;
    st  = stall ? 1 : 0;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (valid) got = 1'b1;
      else if (stall) st++;
    end
    chk("done_reached", 64'(got), 64'd1);
    chk("stall_cycles", 64'(st), (y == 32'd0) ? 64'd1 : 64'd33);
    chk("done_stall", 64'(stall), 64'd0);
    if (hold_n > 0) begin
      hold = 1'b1;
      for (int k = 0; k < hold_n; k++) begin
        @(negedge clk);
        chk("hold_stall", 64'(stall), 64'd0);
        chk("hold_valid", 64'(valid), 64'd1);
        chk("hold_lo", lo, e.lo);
        chk("hold_hi", hi, e.hi);
      end
    end
    hold = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("idle_valid", 64'(valid), 64'd0);
    chk("idle_stall", 64'(stall), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] ra, rb;
    rst = 1'b1; start = 1'b0; sgn = 1'b0; mexc = 1'b0; hold = 1'b0;
    a = '0; b = '0;
    repeat (3) @(negedge clk);
    chk("rst_lo", lo, 0);
    chk("rst_hi", hi, 0);
    chk("rst_valid", 64'(valid), 0);
    chk("rst_stall", 64'(stall), 0);
    rst = 1'b0;
    @(negedge clk);

    do_div(32'd100, 32'd7, 1'b0, 0);
    do_div(32'hFFFF_FFF9, 32'd2, 1'b1, 0);
    do_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0);
    do_div(32'h0000_1234, 32'd0, 1'b0, 0);
    do_div($urandom, $urandom_range(1, 1000), 1'b1, 5);

    // Abort in BUSY cycle 10.
    start = 1'b1; sgn = 1'b0; a = 32'd5000; b = 32'd3;
    repeat (10) @(negedge clk);
    mexc = 1'b1; start = 1'b0;
    @(negedge clk);
    chk("abort_stall", 64'(stall), 0);
    chk("abort_valid", 64'(valid), 0);
    mexc = 1'b0;
    do_div(32'd9, 32'd3, 1'b0, 0);

    // Abort in DONE wins over the hold.
    exp_q.push_back(model(32'hCAFE_0001, 32'd0, 1'b1));
    start = 1'b1; sgn = 1'b1; a = 32'hCAFE_0001; b = 32'd0;
    @(negedge clk);
    chk("dz_done_valid", 64'(valid), 1);
    mexc = 1'b1; hold = 1'b1; start = 1'b0;
    @(negedge clk);
    chk("abort_done_valid", 64'(valid), 0);
    chk("abort_done_stall", 64'(stall), 0);
    mexc = 1'b0; hold = 1'b0;

    // Reset mid-BUSY, then a fresh divide.
    start = 1'b1; sgn = 1'b0; a = 32'd77777; b = 32'd13;
    repeat (5) @(negedge clk);
    rst = 1'b1; start = 1'b0;
    #1;
    chk("midrst_lo", lo, 0);
    chk("midrst_hi", hi, 0);
    chk("midrst_valid", 64'(valid), 0);
    chk("midrst_stall", 64'(stall), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    do_div(32'd1_000_000, 32'd999, 1'b0, 0);

    // Randomized back-to-back divides.
    for (int n = 0; n < 16; n++) begin
      ra = $urandom;
      case ($urandom_range(0, 7))
        0:       rb = 32'd0;
        1, 2:    rb = $urandom_range(1, 15);
        3:       rb = 32'hFFFF_FFFF - $urandom_range(0, 3);
        default: rb = $urandom;
      endcase
      do_div(ra, rb, 1'($urandom_range(0, 1)), int'($urandom_range(0, 2)));
    end

    chk("queue_drained", 64'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
